// File: rtl/fifo_counted.sv
// Single-clock FIFO with fill count, threshold flags, sticky error flags and
// a selectable standard (registered) or first-word-fall-through read port.
module fifo_counted #(
  parameter int DATA_WIDTH         = 8,
  parameter int FIFO_SIZE          = 16,
  parameter int COUNT_WIDTH        = 5,
  parameter int ALMOST_FULL_LEVEL  = 12,
  parameter int ALMOST_EMPTY_LEVEL = 2,
  parameter int FWFT               = 0
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   clear_errors,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   pushed_last,
  output logic                   popped_last,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;
  localparam logic [COUNT_WIDTH-1:0] SIZE_C = COUNT_WIDTH'(FIFO_SIZE);
  localparam logic [COUNT_WIDTH-1:0] LAST_C = COUNT_WIDTH'(FIFO_SIZE - 1);
  localparam logic [COUNT_WIDTH-1:0] AF_C   = COUNT_WIDTH'(ALMOST_FULL_LEVEL);
  localparam logic [COUNT_WIDTH-1:0] AE_C   = COUNT_WIDTH'(ALMOST_EMPTY_LEVEL);
  localparam logic [COUNT_WIDTH-1:0] ONE_C  = COUNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0]  mem [FIFO_SIZE];

  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;
  logic                   almost_full_q, almost_full_d;
  logic                   almost_empty_q, almost_empty_d;
  logic                   pushed_last_q, pushed_last_d;
  logic                   popped_last_q, popped_last_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;

  logic                   push_ok, pop_ok;
  logic [DATA_WIDTH-1:0]  head_word;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head_word = mem[rd_ptr_q];

  always_comb begin
    // When full, a pop in the same cycle frees the slot the push then fills.
    pop_ok  = pop && !empty_q;
    push_ok = push && (!full_q || pop_ok);

    wr_ptr_d = push_ok ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? next_ptr(rd_ptr_q) : rd_ptr_q;

    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    full_d         = (count_d == SIZE_C);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= AF_C);
    almost_empty_d = (count_d <= AE_C);

    pushed_last_d = push_ok && !pop_ok && (count_q == LAST_C);
    popped_last_d = pop_ok && !push_ok && (count_q == ONE_C);

    // A fresh error event outranks clear_errors in the same cycle.
    if (push && !push_ok)  overflow_d = 1'b1;
    else if (clear_errors) overflow_d = 1'b0;
    else                   overflow_d = overflow_q;

    if (pop && empty_q)    underflow_d = 1'b1;
    else if (clear_errors) underflow_d = 1'b0;
    else                   underflow_d = underflow_q;

    out_data_d  = pop_ok ? head_word : out_data_q;
    out_valid_d = pop_ok;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      pushed_last_q  <= 1'b0;
      popped_last_q  <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      pushed_last_q  <= pushed_last_d;
      popped_last_q  <= popped_last_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head is exposed directly; masked while empty so reset reads as zero.
      assign out_data  = empty_q ? '0 : head_word;
      assign out_valid = !empty_q;
    end else begin : g_std
      assign out_data  = out_data_q;
      assign out_valid = out_valid_q;
    end
  endgenerate

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign pushed_last  = pushed_last_q;
  assign popped_last  = popped_last_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: doc/fifo_counted.md
Name: fifo_counted

Overview:
- Parametrised successor to the 8-bit byte FIFO used between the RS232 receiver/transmitter and the host-side logic.
- Adds the following over the plain push/pop FIFO:
  - arbitrary (non-power-of-2) depth and width
  - fill count
  - full/empty and programmable almost-full/almost-empty flags
  - sticky overflow/underflow error flags
  - selectable standard or first-word-fall-through (FWFT) read mode
- Single clock domain; sits directly behind the UART RX deserialiser and in front of the TX serialiser.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- FIFO_SIZE, 16, depth in words; any value >= 2.
- COUNT_WIDTH, 5, width of count; must satisfy 2^COUNT_WIDTH > FIFO_SIZE.
- ALMOST_FULL_LEVEL, 12, almost_full asserted when count >= this; 0 < level < FIFO_SIZE.
- ALMOST_EMPTY_LEVEL, 2, almost_empty asserted when count <= this; must be < ALMOST_FULL_LEVEL.
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  rising-edge clock.
- clear  in  1  asynchronous active-high reset.
- push  in  1  write request, sampled on clk rise.
- pop  in  1  read request, sampled on clk rise.
- in_data  in  DATA_WIDTH  write data.
- clear_errors  in  1  synchronous clear of overflow/underflow.
- out_data  out  DATA_WIDTH  read data.
- out_valid  out  1  out_data qualifier.
- count  out  COUNT_WIDTH  words stored.
- full  out  1  count == FIFO_SIZE.
- empty  out  1  count == 0.
- almost_full  out  1  count >= ALMOST_FULL_LEVEL.
- almost_empty  out  1  count <= ALMOST_EMPTY_LEVEL.
- pushed_last  out  1  1-cycle pulse: accepted push made FIFO full.
- popped_last  out  1  1-cycle pulse: accepted pop made FIFO empty.
- overflow  out  1  sticky: push attempted while full and not accepted.
- underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (clear high, asynchronous, holds while high):
  - wr_ptr = rd_ptr = 0, count = 0
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0
  - out_data = 0, out_valid = 0
  - pushed_last = popped_last = 0, overflow = underflow = 0
  - Memory contents are not reset.
  - Reset mid-operation discards all stored words.
- Pointers advance by 1 and wrap from FIFO_SIZE-1 to 0; no power-of-2 requirement.
- All flags and count are registered and update on the same edge as the pointers. There is no combinational path from push/pop to any flag.
- Accepted push (push=1 and not full, or push=1 and pop accepted while full):
  - mem[wr_ptr] <= in_data; wr_ptr advances.
- Accepted pop (pop=1 and not empty):
  - rd_ptr advances.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- FWFT=0 read:
  - Accepted pop registers mem[rd_ptr] into out_data at that edge; out_valid = 1 for exactly that following cycle (latency 1).
  - Otherwise out_valid = 0 and out_data holds its last value.
- FWFT=1 read:
  - out_data = mem[rd_ptr] continuously; out_valid = !empty.
  - An accepted pop exposes the next word after the edge.
  - A word written into an empty FIFO appears on out_data the cycle after the push edge.
- Simultaneous push and pop:
  - 0 < count < FIFO_SIZE: both accepted; count unchanged.
  - Empty: push accepted; pop rejected; underflow set; out_valid (FWFT=0) stays 0.
  - Full: both accepted; count stays FIFO_SIZE; no overflow. The popped word is the old head; the new word is written to the freed slot.
- Rejected push (full, no pop): memory and wr_ptr unchanged; overflow <= 1.
- Rejected pop (empty): rd_ptr and out_data unchanged; underflow <= 1.
- pushed_last: pulses for 1 cycle when count goes FIFO_SIZE-1 -> FIFO_SIZE.
- popped_last: pulses for 1 cycle when count goes 1 -> 0.
- clear_errors=1 zeroes overflow and underflow next edge. A new error event in the same cycle wins, so the flag stays 1.

Test Plan:
- Reset/idle: assert clear 100 ns mid-clock with FIFO_SIZE=3 -> all outputs at reset values immediately, before any clk edge; empty=1, count=0.
- Fill/drain, FWFT=0, FIFO_SIZE=3:
  - Push 8'hAC, 8'h61, 8'h11 -> count 1,2,3; full=1 after third edge; pushed_last pulses once on third.
  - 4th push 8'h39 -> overflow=1, count=3.
  - Pop x3 -> out_data 8'hAC, 8'h61, 8'h11, each with a 1-cycle out_valid; popped_last on third; empty=1.
- Wrap-around: FIFO_SIZE=3, push/pop interleaved 10 words 8'h00..8'h09 -> read order identical, pointers wrap, no error flags.
- Simultaneous ops:
  - Full + push+pop -> count stays 3, head returned, new word read last.
  - Empty + push+pop -> count=1, underflow=1.
  - clear_errors same cycle as a new underflow -> underflow stays 1.
- FWFT=1: push 8'h7D into empty -> out_valid=1 and out_data=8'h7D one cycle later without pop; pop -> out_valid=0, empty=1.
- Thresholds: FIFO_SIZE=16, AF=12, AE=2, push 16 then pop 16 -> almost_empty drops at count 3, almost_full rises at 12 and falls at 11; count matches a reference model every cycle.
